// File: rtl/dilated_tap_scheduler.sv
// Causal dilated 1D convolution sequencer: keeps an H-row history ring, issues
// one row multiply per kernel tap over a shared multiplier, accumulates the K
// lane-wise results and emits one output row per accepted input row.
module dilated_tap_scheduler #(
    parameter int W   = 16,
    parameter int D   = 8,
    parameter int K   = 4,
    parameter int DIL = 2,
    localparam int H  = (K - 1) * DIL + 1,
    localparam int TW = (K > 1) ? $clog2(K) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [D*W-1:0]    in_data,
    input  logic              in_v,
    output logic              in_ready,
    output logic [D*W-1:0]    mm_a,
    output logic [TW-1:0]     mm_tap,
    output logic              mm_start,
    input  logic [2*D*W-1:0]  mm_out,
    input  logic              mm_out_v,
    output logic [2*D*W-1:0]  out_data,
    output logic              out_v,
    output logic              busy
);

    localparam int PW = (H > 1) ? $clog2(H) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Ring slot read by tap k: (wp - k*DIL) mod H; k*DIL never exceeds H-1.
    function automatic logic [PW-1:0] tap_slot(input logic [PW-1:0] wp, input logic [TW-1:0] k);
        int s;
        s = int'(wp) + H - int'(k) * DIL;
        if (s >= H) begin
            s = s - H;
        end else begin
            s = s;
        end
        return PW'(s);
    endfunction

    // Lane-wise 2W-bit wrapping addition; lanes never carry into each other.
    function automatic logic [2*D*W-1:0] lane_add(input logic [2*D*W-1:0] a, input logic [2*D*W-1:0] b);
        logic [2*D*W-1:0] r;
        r = '0;
        for (int j = 0; j < D; j++) begin
            r[j*2*W +: 2*W] = a[j*2*W +: 2*W] + b[j*2*W +: 2*W];
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [PW-1:0]       wp_q, wp_d;
    logic [TW-1:0]       k_q, k_d;
    logic [2*D*W-1:0]    acc_q, acc_d;
    logic [2*D*W-1:0]    out_data_q, out_data_d;
    logic                out_v_q, out_v_d;
    logic                mm_start_q, mm_start_d;
    logic [D*W-1:0]      mm_a_q, mm_a_d;
    logic [TW-1:0]       mm_tap_q, mm_tap_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                hist_we_d;
    logic [D*W-1:0]      hist_q [H];

    // Next-state logic: FSM transitions, tap counter, accumulator, ring pointer.
    always_comb begin
        state_d   = state_q;
        wp_d      = wp_q;
        k_d       = k_q;
        acc_d     = acc_q;
        hist_we_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_v) begin
                    hist_we_d = 1'b1;
                    acc_d     = '0;
                    k_d       = '0;
                    state_d   = S_ISSUE;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mm_out_v) begin
                    acc_d = lane_add(acc_q, mm_out);
                    if (k_q == TW'(K - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + TW'(1);
                        state_d = S_ISSUE;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                wp_d    = (wp_q == PW'(H - 1)) ? '0 : wp_q + PW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values derived from the next state so every port is registered.
    always_comb begin
        mm_start_d = 1'b0;
        mm_a_d     = '0;
        mm_tap_d   = '0;
        if (state_d == S_ISSUE) begin
            mm_start_d = 1'b1;
            mm_tap_d   = k_d;
            // Tap 0 of a fresh row reads the slot being written this cycle.
            if (state_q == S_IDLE) begin
                mm_a_d = in_data;
            end else begin
                mm_a_d = hist_q[tap_slot(wp_q, k_d)];
            end
        end else begin
            mm_start_d = 1'b0;
        end
        out_v_d    = (state_d == S_DONE);
        out_data_d = (state_d == S_DONE) ? acc_d : out_data_q;
        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wp_q       <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_v_q    <= 1'b0;
            mm_start_q <= 1'b0;
            mm_a_q     <= '0;
            mm_tap_q   <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            wp_q       <= wp_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_v_q    <= out_v_d;
            mm_start_q <= mm_start_d;
            mm_a_q     <= mm_a_d;
            mm_tap_q   <= mm_tap_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    // History ring; cleared on reset so unwritten slots act as causal zero padding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < H; i++) begin
                hist_q[i] <= '0;
            end
        end else if (hist_we_d) begin
            hist_q[wp_q] <= in_data;
        end
    end

    assign in_ready = in_ready_q;
    assign mm_a     = mm_a_q;
    assign mm_tap   = mm_tap_q;
    assign mm_start = mm_start_q;
    assign out_data = out_data_q;
    assign out_v    = out_v_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dilated_tap_scheduler.sv
// Self-checking bench for dilated_tap_scheduler: mock multiplier with a
// configurable response, queue-based reference model of the convolution.
module tb_dilated_tap_scheduler;

    localparam int W   = 16;
    localparam int D   = 8;
    localparam int K   = 4;
    localparam int DIL = 2;
    localparam int TW  = 2;
    localparam int DW  = D * W;
    localparam int OW  = 2 * D * W;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic            in_v;
    logic            in_ready;
    logic [DW-1:0]   mm_a;
    logic [TW-1:0]   mm_tap;
    logic            mm_start;
    logic [OW-1:0]   mm_out;
    logic            mm_out_v;
    logic [OW-1:0]   out_data;
    logic            out_v;
    logic            busy;

    logic            mock_v, spur_v;
    logic [OW-1:0]   mock_d, spur_d;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat_L   = 3;
    int mode    = 0;
    int tap_exp = 0;
    logic [DW-1:0] rows[$];
    int start_log[$];

    assign mm_out_v = mock_v | spur_v;
    assign mm_out   = mock_v ? mock_d : spur_d;

    dilated_tap_scheduler #(.W(W), .D(D), .K(K), .DIL(DIL)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_v(in_v), .in_ready(in_ready),
        .mm_a(mm_a), .mm_tap(mm_tap), .mm_start(mm_start), .mm_out(mm_out),
        .mm_out_v(mm_out_v), .out_data(out_data), .out_v(out_v), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_of(input logic [DW-1:0] r, input int j);
        return r[(D-1-j)*W +: W];
    endfunction

    // Row seen by tap k of the newest row: the row k*DIL samples earlier, or zero.
    function automatic logic [DW-1:0] exp_row(input int k);
        int idx;
        idx = rows.size() - 1 - k * DIL;
        if (idx < 0) return '0;
        return rows[idx];
    endfunction

    // Mock multiplier response for one lane.
    function automatic logic [31:0] fval(input logic [W-1:0] a, input int tap, input int md);
        int v;
        v = $signed(a);
        case (md)
            0: return 32'(v * (tap + 1));
            1: return 32'hFFFF_FFFF;
            default: return (tap == 0) ? 32'h7FFF_FFFF : ((tap == 1) ? 32'd1 : 32'd0);
        endcase
    endfunction

    function automatic logic [OW-1:0] exp_out();
        logic [OW-1:0] r;
        logic [31:0]   s;
        r = '0;
        for (int j = 0; j < D; j++) begin
            s = 32'd0;
            for (int k = 0; k < K; k++) s = s + fval(lane_of(exp_row(k), j), k, mode);
            r[(D-1-j)*32 +: 32] = s;
        end
        return r;
    endfunction

    // Mock multiplier: checks each issue, answers lat_L cycles later.
    initial begin
        mock_v = 1'b0;
        mock_d = '0;
        forever begin
            @(negedge clk);
            mock_v = 1'b0;
            if (mm_start === 1'b1) begin
                start_log.push_back(cyc);
                chk("mm_tap", OW'(mm_tap), OW'(tap_exp));
                chk("mm_a", OW'(mm_a), OW'(exp_row(tap_exp)));
                for (int j = 0; j < D; j++)
                    mock_d[(D-1-j)*32 +: 32] = fval(lane_of(mm_a, j), int'(mm_tap), mode);
                tap_exp = (tap_exp + 1) % K;
                repeat (lat_L) @(negedge clk);
                mock_v = 1'b1;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, " out_data"}, out_data, '0);
        chk({tag, " out_v"}, OW'(out_v), '0);
        chk({tag, " mm_start"}, OW'(mm_start), '0);
        chk({tag, " mm_a"}, OW'(mm_a), '0);
        chk({tag, " mm_tap"}, OW'(mm_tap), '0);
        chk({tag, " busy"}, OW'(busy), '0);
        chk({tag, " in_ready"}, OW'(in_ready), OW'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rows.delete();
        tap_exp = 0;
    endtask

    task automatic send_row(input logic [DW-1:0] row, input bit spur, output int t_acc);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready wait", OW'(in_ready), OW'(1));
        rows.push_back(row);
        in_data = row;
        in_v    = 1'b1;
        t_acc   = cyc;
        @(negedge clk);
        in_v = 1'b0;
        chk("busy after accept", OW'(busy), OW'(1));
        if (spur) begin
            spur_d = {D{32'h1234_5678}};
            spur_v = 1'b1;
            @(negedge clk);
            spur_v = 1'b0;
        end
    endtask

    task automatic wait_out(input int t_acc, input logic [OW-1:0] e, input string tag);
        int n;
        n = 0;
        while (out_v !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " out_v seen"}, OW'(out_v), OW'(1));
        chk({tag, " latency"}, OW'(cyc - t_acc), OW'(1 + K * (lat_L + 1)));
        chk({tag, " out_data"}, out_data, e);
        @(negedge clk);
        chk({tag, " out_v one cycle"}, OW'(out_v), '0);
        chk({tag, " out_data hold"}, out_data, e);
    endtask

    task automatic do_row(input logic [DW-1:0] row, input bit spur, input string tag);
        int t;
        logic [OW-1:0] e;
        send_row(row, spur, t);
        e = exp_out();
        wait_out(t, e, tag);
    endtask

    initial begin
        int t, t2, n;
        bit seen;
        logic [DW-1:0] ra, rb, rr;
        logic [OW-1:0] ea, eb;
        rst = 1'b1; in_v = 1'b0; in_data = '0; spur_v = 1'b0; spur_d = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single row: issue timing, taps, zero padding.
        start_log.delete();
        send_row({D{16'd1}}, 1'b0, t);
        ea = exp_out();
        wait_out(t, ea, "single");
        chk("single const", out_data, {D{32'd1}});
        chk("single issues", OW'(start_log.size()), OW'(K));
        for (int i = 0; i < K && i < start_log.size(); i++)
            chk("single start cycle", OW'(start_log[i]), OW'(t + 1 + i * (lat_L + 1)));

        // Stream x0..x6 with ring wrap.
        do_reset();
        for (int i = 0; i < 7; i++) do_row({D{16'(i + 1)}}, 1'b0, "stream");
        chk("stream x6 const", out_data, {D{32'd30}});
        do_row({D{16'd8}}, 1'b0, "stream wrap");

        // Spurious results in IDLE and ISSUE.
        @(negedge clk);
        spur_d = {D{32'h0BAD_0BAD}}; spur_v = 1'b1;
        @(negedge clk);
        spur_v = 1'b0;
        do_row({D{16'hFFFE}}, 1'b1, "spurious");

        // Backpressure: in_v held high while busy, data changes underneath.
        for (int j = 0; j < D; j++) begin ra[j*W +: W] = 16'($urandom); rb[j*W +: W] = 16'($urandom); end
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        rows.push_back(ra); in_data = ra; in_v = 1'b1; t = cyc; ea = exp_out();
        @(negedge clk);
        in_data = rb;
        chk("bp in_ready low", OW'(in_ready), '0);
        wait_out(t, ea, "bp A");
        chk("bp in_ready idle", OW'(in_ready), OW'(1));
        rows.push_back(rb); t2 = cyc; eb = exp_out();
        @(negedge clk);
        in_v = 1'b0;
        wait_out(t2, eb, "bp B");
        do_row({D{16'd3}}, 1'b0, "bp C");
        do_row({D{16'd4}}, 1'b0, "bp D");

        // Arithmetic edges.
        mode = 1;
        do_row({D{16'd9}}, 1'b0, "neg one");
        chk("neg one const", out_data, {D{32'hFFFF_FFFC}});
        mode = 2;
        do_row({D{16'd9}}, 1'b0, "wrap");
        chk("wrap const", out_data, {D{32'h8000_0000}});
        mode = 0;

        // Randomized rows and multiplier latencies.
        for (int r = 0; r < 20; r++) begin
            lat_L = $urandom_range(1, 4);
            for (int j = 0; j < D; j++) rr[j*W +: W] = 16'($urandom);
            do_row(rr, 1'b0, "random");
        end
        lat_L = 3;

        // Reset while waiting after the second issue.
        start_log.delete();
        send_row({D{16'd7}}, 1'b0, t);
        n = 0;
        while (start_log.size() < 2 && n < 100) begin @(negedge clk); n++; end
        chk("abort second issue", OW'(start_log.size() >= 2), OW'(1));
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); if (out_v === 1'b1) seen = 1'b1; end
        rst = 1'b0;
        check_reset_state("abort");
        repeat (8) begin @(negedge clk); if (out_v === 1'b1) seen = 1'b1; end
        chk("abort no out_v", OW'(seen), '0);
        rows.delete();
        tap_exp = 0;
        do_row({D{16'd5}}, 1'b0, "after abort");
        chk("after abort const", out_data, {D{32'd5}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dilated_tap_scheduler.md
Name: dilated_tap_scheduler

Overview:
- Sequences one causal dilated 1D convolution layer over a single shared row-by-matrix multiplier.
- Per accepted input row: stores the row in a history ring buffer, issues K row multiplies (one per kernel tap, each with its own weight bank), lane-wise accumulates the K results, then emits one output row.
- Sits between the upstream activation stream and the multiplier; one instance per layer.

Parameters:
- W, 16, element width of input lanes.
- D, 8, lanes per row; multiplier is (1,D).(D,D).
- K, 4, kernel taps (>=1).
- DIL, 2, dilation in samples (>=1).
- Derived: H = (K-1)*DIL+1 history depth; TW = max(1, clog2(K)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_data  in  D*W  input row, signed lanes.
- in_v  in  1  input valid.
- in_ready  out  1  block can accept a row.
- mm_a  out  D*W  row to multiplier.
- mm_tap  out  TW  weight bank select for this issue.
- mm_start  out  1  one-cycle issue strobe.
- mm_out  in  2*D*W  multiplier result.
- mm_out_v  in  1  one-cycle result strobe, L>=1 cycles after mm_start.
- out_data  out  2*D*W  accumulated output row.
- out_v  out  1  one-cycle output strobe.
- busy  out  1  high in any state but IDLE.

Behaviour:
- Lane packing: lane 0 in MSBs of each bus. Lane j of in_data/mm_a is W bits; lane j of mm_out/out_data is 2W bits. Lanes are independent.
- Reset, async: state=IDLE, history all zero, wp=0, k=0, accumulator=0, out_data=0, out_v=0, mm_start=0, mm_a=0, mm_tap=0, busy=0, in_ready=1.
- History: H-row ring buffer, wp = slot of newest row. Tap k reads slot (wp - k*DIL) mod H, wrapping modulo H. Never-written slots read as zero (causal padding).
- FSM:
  - IDLE: in_ready=1. On in_v: write in_data to history[wp], clear accumulator, k=0, go to ISSUE.
  - ISSUE: exactly one cycle. mm_start=1, mm_a=history[(wp-k*DIL) mod H], mm_tap=k. Go to WAIT.
  - WAIT: on mm_out_v, accumulator[j] += mm_out[j] for every lane, 2W-bit two's complement, wraps with no saturation. If k==K-1 go to DONE, else k++ and go to ISSUE.
  - DONE: out_data = accumulator (registered), out_v=1 for exactly this cycle, wp = (wp+1) mod H. Go to IDLE.
- Outside ISSUE: mm_start=0, mm_a=0, mm_tap=0.
- in_ready=0 in every state but IDLE. An upstream row holding in_v is accepted in the first IDLE cycle.
- mm_out_v in any state but WAIT is ignored; it does not touch the accumulator.
- out_data holds its value until the next DONE.
- Latency: accept at cycle T gives out_v at T+1+K*(L+1). The next accept is possible at T+2+K*(L+1).
- rst asserted in any state aborts the operation: no out_v, history cleared, and any later mm_out_v for the aborted issue is ignored once in IDLE.

Test Plan:
- Reset check: assert rst mid-stream, release -> all outputs 0, in_ready=1, busy=0. First row's taps 1..3 read zero rows.
- Single row (K=4, DIL=2, mock multiplier L=3), x0 all lanes 1 accepted at T:
  - mm_start at T+1, T+5, T+9, T+13.
  - mm_tap = 0,1,2,3; mm_a = x0, 0, 0, 0.
  - out_v only at T+17.
- Stream x0..x6 with lane value n+1, mock returns lane*(tap+1) sign-extended -> output for x6 = 7*1+5*2+3*3+1*4 = 30 in every lane. Ring wrap verified (H=7, wp wraps 6->0).
- Backpressure: in_v held high during busy -> in_ready=0, no extra history write. Row accepted in the IDLE cycle after out_v. Exactly one out_v per row.
- Arithmetic edges:
  - mock returns -1 on all four taps -> out lanes 0xFFFFFFFC.
  - taps return 0x7FFFFFFF then 1 (others 0) -> lane 0x80000000 (wrap).
  - spurious mm_out_v in IDLE/ISSUE -> no accumulator change.
- Reset in WAIT after the second issue: no out_v, history zero. Next row x=5 produces taps 1..3 with mm_a=0, output 5*1 per lane with the mock above.
